// File: rtl/cc_line_fill_unit.sv
// Line-fill collector: snoops completed AXI R beats of a critical-word-first
// wrap burst, assembles the 512-bit line in address order and writes it once.
module cc_line_fill_unit #(
    parameter int unsigned INDEX_W = 9,
    parameter int unsigned TAG_W   = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [INDEX_W-1:0] req_index_i,
    input  logic [TAG_W-1:0]   req_tag_i,
    input  logic [5:0]         req_offset_i,
    input  logic [63:0]        mem_rdata_i,
    input  logic               mem_rlast_i,
    input  logic               mem_rvalid_i,
    input  logic               mem_rready_i,
    output logic               fill_valid_o,
    input  logic               fill_ready_i,
    output logic [INDEX_W-1:0] fill_index_o,
    output logic [TAG_W-1:0]   fill_tag_o,
    output logic [511:0]       fill_data_o,
    output logic               fill_err_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] start_q;
    logic [2:0] count_q;
    logic [2:0] slot;
    logic       beat;
    logic       err_d;

    assign beat = mem_rvalid_i & mem_rready_i;
    // 3-bit add wraps naturally, giving the critical-word-first slot order
    assign slot = start_q + count_q;

    assign req_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign fill_valid_o = (state_q == S_WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (beat) begin
                    if (count_q == 3'd7) begin
                        if (mem_rlast_i) begin
                            state_d = S_WRITE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (mem_rlast_i) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (fill_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_index_o <= '0;
            fill_tag_o   <= '0;
            fill_data_o  <= '0;
            fill_err_o   <= 1'b0;
            start_q      <= '0;
            count_q      <= '0;
        end else begin
            fill_err_o <= err_d;
            if (state_q == S_IDLE && req_valid_i) begin
                fill_index_o <= req_index_i;
                fill_tag_o   <= req_tag_i;
                fill_data_o  <= '0;
                start_q      <= req_offset_i[5:3];
                count_q      <= '0;
            end else if (state_q == S_COLLECT && beat) begin
                count_q <= count_q + 3'd1;
                // a malformed burst discards whatever was collected
                if (err_d) begin
                    fill_data_o <= '0;
                end else begin
                    for (int unsigned w = 0; w < 8; w++) begin
                        if (slot == 3'(w)) begin
                            fill_data_o[64*w +: 64] <= mem_rdata_i;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/cc_line_fill_unit.md
# cc_line_fill_unit

Line-fill collector for the cache controller's miss path. It passively monitors the memory-to-controller AXI R channel, the same beats the data reorder unit forwards to the interconnect. It assembles the 8 x 64-bit critical-word-first wrap burst of a pending miss into a 512-bit line in address order, then issues a single write of that line to the data/tag SRAM. It never drives the R channel's rready; it only observes completed handshakes.

## Interface
- INDEX_W, 9, cache set index width
- TAG_W, 17, tag width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid_i  input  1  miss registered for fill
- req_ready_o  output  1  unit can accept a miss
- req_index_i  input  INDEX_W  set index of miss
- req_tag_i  input  TAG_W  tag of miss
- req_offset_i  input  6  byte offset of missing address; bits [5:3] = critical word
- mem_rdata_i  input  64  R data being forwarded
- mem_rlast_i  input  1  R last
- mem_rvalid_i  input  1  R valid
- mem_rready_i  input  1  R ready as driven by the reorder unit (observed only)
- fill_valid_o  output  1  line write request to SRAM
- fill_ready_i  input  1  SRAM accepts write this cycle
- fill_index_o  output  INDEX_W  line set index
- fill_tag_o  output  TAG_W  line tag
- fill_data_o  output  512  line data; word w at bits [64w+63:64w]
- fill_err_o  output  1  one-cycle pulse on burst-length violation
- busy_o  output  1  state != IDLE

## Operation
- States: IDLE, COLLECT, WRITE.
- IDLE: req_ready_o=1. On req_valid_i, capture index, tag, and start word (req_offset_i[5:2+1]), clear beat count, go to COLLECT. R beats seen in IDLE are ignored; no error.
- COLLECT: req_ready_o=0. A beat is a cycle with mem_rvalid_i & mem_rready_i. Beat k (k=0..7) is written to word slot (start + k) mod 8 using 3-bit wrap-around arithmetic. The count increments per beat.
  - Beat 7 with mem_rlast_i=1: go to WRITE.
  - Beat k<7 with mem_rlast_i=1 (early last): pulse fill_err_o, discard the line, go to IDLE.
  - Beat 7 with mem_rlast_i=0 (missing last): pulse fill_err_o, discard, go to IDLE. Remaining beats up to the next last are ignored in IDLE.
- WRITE: fill_valid_o=1. Index, tag, and data are stable until fill_ready_i. The cycle fill_valid_o & fill_ready_i is true, go to IDLE.
- Only one miss is outstanding. A new request is accepted no earlier than the cycle after the WRITE handshake. The upstream guarantees that the first R beat of a miss arrives at least one cycle after its request is accepted.
- Data captured is exactly mem_rdata_i at the handshake. Word slots not written this burst cannot reach the output, because errors discard the line.

## Timing
- Reset values: req_ready_o=1 (IDLE), fill_valid_o=0, fill_err_o=0, busy_o=0, fill_index_o=0, fill_tag_o=0, fill_data_o=0. Beat count = 0.
- Reset asserted in any state returns to IDLE on the next edge and discards all partial data. It takes priority over every other event.
- Request acceptance: busy_o=1 the cycle after the req handshake.
- Fill latency: fill_valid_o asserts the cycle after the 8th beat handshake. Minimum request-to-fill is 9 cycles for back-to-back beats.
- Beats may be gapped arbitrarily. Cycles with rvalid=0 or rready=0 change nothing.
- fill_err_o is high for exactly the cycle after the offending beat, coincident with the return to IDLE (busy_o=0).
- fill_ready_i held high on WRITE entry gives a 1-cycle fill_valid_o pulse. req_ready_o returns high the next cycle.
- fill_ready_i outside WRITE is ignored.
- Outputs are registered; no combinational path from inputs to outputs except none (req_ready_o is derived from state only).

## Test plan
- Aligned fill: req offset 0x00, index 0x05, tag 0x1ABCD, beats D0..D7 = 0x1000+k back-to-back with last on beat 7 -> fill_valid_o the next cycle; fill_data_o word k = 0x1000+k; index and tag echoed.
- Critical-word-first wrap: req offset 0x28 (word 5), beats B0..B7 -> words 5,6,7,0,1,2,3,4 hold B0..B7; word 0 = B3.
- Backpressure and gaps: rvalid toggled and rready low on alternate cycles, fill_ready_i held low 4 cycles -> only handshaked beats captured; fill_valid_o and data held stable 4 cycles, then drops one cycle after fill_ready_i.
- Early last at beat 3: fill_err_o 1-cycle pulse, no fill_valid_o, busy_o=0, req_ready_o=1. A following clean burst fills correctly.
- Missing last on beat 7: fill_err_o pulse, no fill. Stray beats in IDLE are ignored without error.
- Reset mid-COLLECT after 4 beats: the next cycle shows all outputs at reset values. A new request fills correctly with no old data leaking.
